// File: rtl/pkt_tx_scheduler.sv
// -----------------------------------------------------------------------------
// pkt_tx_scheduler
//
// Round-robin scheduler that shares one sop/vld/eop/len packet bus between NREQ
// requesters. A requester posts a packet length; the winner's packet is emitted
// beat by beat (honouring rdy backpressure), followed by GAP idle cycles.
//
// Optional feature macro: SCHED_STATS_EN (adds pkt_cnt / beat_cnt counters).
//
// Ports:
//   clk      : clock, all logic on posedge
//   rst      : synchronous, active-high reset
//   req      : per-requester request, held until its gnt pulse
//   req_len  : per-requester length, requester i uses [i*LW +: LW]
//   gnt      : one-hot, single-cycle grant pulse
//   sop/vld/eop : packet framing of the output bus
//   len      : length of current packet (0 when vld=0)
//   out_id   : owner of current packet (0 when vld=0)
//   rdy      : downstream accept, a beat transfers on vld && rdy
//   busy     : high while sending a packet or in the idle gap
//   pkt_cnt  : (SCHED_STATS_EN) accepted eop beats, wraps
//   beat_cnt : (SCHED_STATS_EN) accepted beats, wraps
// -----------------------------------------------------------------------------
module pkt_tx_scheduler #(
    parameter int NREQ = 4,
    parameter int LW   = 4,
    parameter int GAP  = 1,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*LW-1:0]   req_len,
    output logic [NREQ-1:0]      gnt,
    output logic                 sop,
    output logic                 vld,
    output logic                 eop,
    output logic [LW-1:0]        len,
    output logic [IDW-1:0]       out_id,
    input  logic                 rdy,
    output logic                 busy
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0]          pkt_cnt,
    output logic [15:0]          beat_cnt
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Gap counter counts down to zero, so it is loaded with GAP-1.
    localparam logic [3:0] GAP_LOAD     = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic [1:0] ST_AFTER_EOP = (GAP > 0) ? ST_GAP : ST_IDLE;

    logic [1:0]      state_d,  state_q;
    logic [IDW-1:0]  rr_d,     rr_q;
    logic [LW-1:0]   cnt_d,    cnt_q;
    logic [3:0]      gap_d,    gap_q;
    logic [NREQ-1:0] gnt_d,    gnt_q;
    logic            sop_d,    sop_q;
    logic            vld_d,    vld_q;
    logic            eop_d,    eop_q;
    logic [LW-1:0]   len_d,    len_q;
    logic [IDW-1:0]  id_d,     id_q;
    logic            busy_d,   busy_q;

    logic [NREQ-1:0] elig_s;
    logic            win_found_s;
    logic [IDW-1:0]  win_id_s;
    logic [LW-1:0]   win_len_s;
    logic [NREQ-1:0] win_oh_s;
    logic [IDW-1:0]  win_next_s;

    // Eligibility: a request with a zero length is masked out.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig_s[i] = req[i] && (req_len[i*LW +: LW] != {LW{1'b0}});
        end
    end

    // Round-robin search starting at the pointer, wrapping at NREQ.
    always_comb begin
        win_found_s = 1'b0;
        win_id_s    = {IDW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found_s && elig_s[(int'(rr_q) + k) % NREQ]) begin
                win_found_s = 1'b1;
                win_id_s    = IDW'((int'(rr_q) + k) % NREQ);
            end else begin
                win_found_s = win_found_s;
            end
        end
        win_len_s = req_len[int'(win_id_s)*LW +: LW];
        win_oh_s  = {{(NREQ-1){1'b0}}, 1'b1} << win_id_s;
        if (int'(win_id_s) == NREQ - 1) begin
            win_next_s = {IDW{1'b0}};
        end else begin
            win_next_s = IDW'(int'(win_id_s) + 1);
        end
    end

    // Next-state and next-output computation for the scheduler FSM.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        gnt_d   = {NREQ{1'b0}};
        sop_d   = sop_q;
        vld_d   = vld_q;
        eop_d   = eop_q;
        len_d   = len_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_d = ST_SEND;
                    rr_d    = win_next_s;
                    cnt_d   = win_len_s;
                    gnt_d   = win_oh_s;
                    sop_d   = 1'b1;
                    vld_d   = 1'b1;
                    eop_d   = (win_len_s == LW'(1));
                    len_d   = win_len_s;
                    id_d    = win_id_s;
                end else begin
                    state_d = ST_IDLE;
                    sop_d   = 1'b0;
                    vld_d   = 1'b0;
                    eop_d   = 1'b0;
                    len_d   = {LW{1'b0}};
                    id_d    = {IDW{1'b0}};
                end
            end
            ST_SEND: begin
                if (vld_q && rdy) begin
                    cnt_d = cnt_q - LW'(1);
                    if (cnt_q == LW'(1)) begin
                        // Last beat accepted: clear the bus and start the gap.
                        state_d = ST_AFTER_EOP;
                        gap_d   = GAP_LOAD;
                        sop_d   = 1'b0;
                        vld_d   = 1'b0;
                        eop_d   = 1'b0;
                        len_d   = {LW{1'b0}};
                        id_d    = {IDW{1'b0}};
                    end else begin
                        sop_d = 1'b0;
                        eop_d = (cnt_q == LW'(2));
                    end
                end else begin
                    // Backpressure: every bus field holds its value.
                    state_d = ST_SEND;
                end
            end
            ST_GAP: begin
                sop_d = 1'b0;
                vld_d = 1'b0;
                eop_d = 1'b0;
                len_d = {LW{1'b0}};
                id_d  = {IDW{1'b0}};
                if (gap_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sop_d   = 1'b0;
                vld_d   = 1'b0;
                eop_d   = 1'b0;
                len_d   = {LW{1'b0}};
                id_d    = {IDW{1'b0}};
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rr_q    <= {IDW{1'b0}};
            cnt_q   <= {LW{1'b0}};
            gap_q   <= 4'd0;
            gnt_q   <= {NREQ{1'b0}};
            sop_q   <= 1'b0;
            vld_q   <= 1'b0;
            eop_q   <= 1'b0;
            len_q   <= {LW{1'b0}};
            id_q    <= {IDW{1'b0}};
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            gnt_q   <= gnt_d;
            sop_q   <= sop_d;
            vld_q   <= vld_d;
            eop_q   <= eop_d;
            len_q   <= len_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt    = gnt_q;
    assign sop    = sop_q;
    assign vld    = vld_q;
    assign eop    = eop_q;
    assign len    = len_q;
    assign out_id = id_q;
    assign busy   = busy_q;

`ifdef SCHED_STATS_EN
    logic [15:0] pkt_cnt_d,  pkt_cnt_q;
    logic [15:0] beat_cnt_d, beat_cnt_q;

    // Statistics: count accepted beats and accepted eop beats, wrapping.
    always_comb begin
        if ((state_q == ST_SEND) && vld_q && rdy) begin
            beat_cnt_d = beat_cnt_q + 16'd1;
            if (eop_q) begin
                pkt_cnt_d = pkt_cnt_q + 16'd1;
            end else begin
                pkt_cnt_d = pkt_cnt_q;
            end
        end else begin
            beat_cnt_d = beat_cnt_q;
            pkt_cnt_d  = pkt_cnt_q;
        end
    end

    // Statistics registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q  <= 16'd0;
            beat_cnt_q <= 16'd0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign beat_cnt = beat_cnt_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pkt_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pkt_tx_scheduler
//
// Directed and randomized stimulus for pkt_tx_scheduler (NREQ=4, LW=4, GAP=1).
// Expected outputs come from a packet-level reference model: on each idle
// decision it picks the round-robin winner and queues the full beat list of
// that packet; beats leave the queue as rdy accepts them, then GAP idle cycles
// follow.
// -----------------------------------------------------------------------------
module tb_pkt_tx_scheduler;

    localparam int NREQ = 4;
    localparam int LW   = 4;
    localparam int GAP  = 1;
    localparam int IDW  = 2;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*LW-1:0]  req_len;
    logic [NREQ-1:0]     gnt;
    logic                sop;
    logic                vld;
    logic                eop;
    logic [LW-1:0]       len;
    logic [IDW-1:0]      out_id;
    logic                rdy;
    logic                busy;
`ifdef SCHED_STATS_EN
    logic [15:0]         pkt_cnt;
    logic [15:0]         beat_cnt;
`endif

    pkt_tx_scheduler #(.NREQ(NREQ), .LW(LW), .GAP(GAP)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_len (req_len),
        .gnt     (gnt),
        .sop     (sop),
        .vld     (vld),
        .eop     (eop),
        .len     (len),
        .out_id  (out_id),
        .rdy     (rdy),
        .busy    (busy)
`ifdef SCHED_STATS_EN
        ,
        .pkt_cnt (pkt_cnt),
        .beat_cnt(beat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit sop;
        bit eop;
        int len;
        int id;
    } beat_t;

    beat_t           beats[$];
    int              m_ptr;
    int              m_gap;
    int              m_pkts;
    int              m_beats;
    logic [NREQ-1:0] e_gnt;
    bit              repost;
    int              n_pass;
    int              n_fail;
    int              n_chk;
    int              gnt_order[$];

    function automatic int len_of(int i);
        return int'(req_len[i*LW +: LW]);
    endfunction

    task automatic post(input int i, input int l);
        req_len[i*LW +: LW] = LW'(l);
        req[i] = 1'b1;
    endtask

    // Advances the reference model by one clock using the inputs now applied.
    task automatic model_step();
        bit found;
        found = 1'b0;
        e_gnt = '0;
        if (rst) begin
            beats.delete();
            m_gap   = 0;
            m_ptr   = 0;
            m_pkts  = 0;
            m_beats = 0;
        end else if (beats.size() > 0) begin
            if (rdy) begin
                m_beats++;
                if (beats[0].eop) m_pkts++;
                void'(beats.pop_front());
                if (beats.size() == 0) m_gap = GAP;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (!found && req[i] && len_of(i) != 0) begin
                    found    = 1'b1;
                    e_gnt[i] = 1'b1;
                    m_ptr    = (i + 1) % NREQ;
                    for (int b = 0; b < len_of(i); b++) begin
                        beats.push_back('{sop: (b == 0), eop: (b == len_of(i) - 1),
                                          len: len_of(i), id: i});
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: model, edge, compare all outputs, then requesters react.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("gnt", 32'(gnt), 32'(e_gnt));
        if (beats.size() > 0) begin
            chk("sop",    32'(sop),    32'(beats[0].sop));
            chk("vld",    32'(vld),    32'd1);
            chk("eop",    32'(eop),    32'(beats[0].eop));
            chk("len",    32'(len),    32'(beats[0].len));
            chk("out_id", 32'(out_id), 32'(beats[0].id));
        end else begin
            chk("sop_idle",    32'(sop),    32'd0);
            chk("vld_idle",    32'(vld),    32'd0);
            chk("eop_idle",    32'(eop),    32'd0);
            chk("len_idle",    32'(len),    32'd0);
            chk("out_id_idle", 32'(out_id), 32'd0);
        end
        chk("busy", 32'(busy), 32'((beats.size() > 0) || (m_gap > 0)));
`ifdef SCHED_STATS_EN
        chk("pkt_cnt",  32'(pkt_cnt),  32'(m_pkts  & 16'hFFFF));
        chk("beat_cnt", 32'(beat_cnt), 32'(m_beats & 16'hFFFF));
`endif
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i] === 1'b1) gnt_order.push_back(i);
            if (e_gnt[i] && !repost) req[i] = 1'b0;
        end
    endtask

    initial begin
        n_pass = 0; n_fail = 0; n_chk = 0;
        m_ptr = 0; m_gap = 0; m_pkts = 0; m_beats = 0;
        e_gnt = '0; repost = 1'b0;
        rst = 1'b1; rdy = 1'b1; req = '0; req_len = '0;

        // Reset state.
        #1;
        cycle();
        cycle();
        rst = 1'b0;

        // Single request, requester 2, len 5.
        cycle();
        post(2, 5);
        repeat (12) cycle();

        // Single-beat packets back to back.
        post(0, 1);
        post(3, 1);
        repeat (10) cycle();

        // Round robin with all requesters continuously asking for len 2.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        gnt_order.delete();
        repost = 1'b1;
        for (int i = 0; i < NREQ; i++) post(i, 2);
        repeat (22) cycle();
        repost = 1'b0;
        req = '0;
        repeat (6) cycle();
        chk("rr_count", 32'(gnt_order.size() >= 5), 32'd1);
        if (gnt_order.size() >= 5) begin
            chk("rr_order0", 32'(gnt_order[0]), 32'd0);
            chk("rr_order1", 32'(gnt_order[1]), 32'd1);
            chk("rr_order2", 32'(gnt_order[2]), 32'd2);
            chk("rr_order3", 32'(gnt_order[3]), 32'd3);
            chk("rr_order4", 32'(gnt_order[4]), 32'd0);
        end

        // Backpressure on the second beat of a len-3 packet.
        gnt_order.delete();
        post(1, 3);
        cycle();
        cycle();
        rdy = 1'b0;
        repeat (3) cycle();
        rdy = 1'b1;
        repeat (6) cycle();
        chk("bp_single_gnt", 32'(gnt_order.size()), 32'd1);

        // Zero-length request is never granted.
        gnt_order.delete();
        post(1, 0);
        post(3, 2);
        repeat (10) cycle();
        chk("zero_len_gnts", 32'(gnt_order.size()), 32'd1);
        if (gnt_order.size() == 1) chk("zero_len_winner", 32'(gnt_order[0]), 32'd3);
        req[1] = 1'b0;
        cycle();

        // Reset on the third beat of a len-6 packet, then a tie.
        post(2, 6);
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        gnt_order.delete();
        post(1, 2);
        post(0, 2);
        repeat (12) cycle();
        if (gnt_order.size() > 0) chk("post_rst_tie", 32'(gnt_order[0]), 32'd0);
        else chk("post_rst_tie_seen", 32'd0, 32'd1);

        // Randomized traffic with random backpressure and rare resets.
        for (int c = 0; c < 3000; c++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) post(i, int'($urandom_range(0, 15)));
                end else if (len_of(i) == 0 && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b0;
                end
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
